// File: rtl/isp_uart_pkg.sv
// Shared types and helpers for the ISP UART byte transmitter.
// Optional parity support is selected with the ISP_UART_PARITY_EN macro.
package isp_uart_pkg;

    localparam logic ISP_UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef ISP_UART_PARITY_EN
        PARITY,
`endif
        STOP,
        GAP
    } tx_state_e;

    // Zero-padding narrower words does not change the XOR, so one width serves 5..9 bits.
    function automatic logic even_parity(input logic [8:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/isp_byte_fifo.sv
// Synchronous FIFO with async active-high reset; pointers carry one extra
// wrap bit so full and empty are distinguishable.
module isp_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/isp_uart_driver.sv
// UART byte transmitter feeding a SoC isp_uart_rx pin: FIFO front end, FSM,
// baud counter and shift register. Define ISP_UART_PARITY_EN for an even parity bit.
module isp_uart_driver
    import isp_uart_pkg::*;
#(
    parameter int CLK_DIV    = 8,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int IDLE_BITS  = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          in_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_done
);
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $fatal(1, "isp_uart_driver: CLK_DIV must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "isp_uart_driver: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $fatal(1, "isp_uart_driver: STOP_BITS must be 1 or 2");
    end
    if (IDLE_BITS < 0 || IDLE_BITS > 15) begin : g_bad_idle_bits
        $fatal(1, "isp_uart_driver: IDLE_BITS must be 0..15");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "isp_uart_driver: FIFO_DEPTH must be a power of two >= 2");
    end

    localparam int                 BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0]  BAUD_LOAD = BAUD_W'(CLK_DIV - 1);
    localparam logic [3:0]         LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]         LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [3:0]         LAST_GAP  = 4'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);

    tx_state_e              state, state_n;
    logic [BAUD_W-1:0]      baud, baud_n;
    logic [3:0]             bit_cnt, bit_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic                   tx_q, tx_n;
    logic                   done_q, done_n;
    logic                   pop;
    logic                   tick;
    logic                   full;
    logic                   empty;
    logic [DATA_BITS-1:0]   head;
`ifdef ISP_UART_PARITY_EN
    logic                   parity_q, parity_n;
`endif

    isp_byte_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    assign in_ready = !full;
    assign uart_tx  = tx_q;
    assign tx_done  = done_q;
    assign busy     = (state != IDLE) || !empty;
    assign tick     = (baud == '0);

    // tx_n is the line level for the state being entered, so uart_tx stays registered.
    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_cnt;
        shift_n = shift;
        tx_n    = tx_q;
        done_n  = 1'b0;
        pop     = 1'b0;
`ifdef ISP_UART_PARITY_EN
        parity_n = parity_q;
`endif
        if (state != IDLE) begin
            baud_n = tick ? BAUD_LOAD : baud - 1'b1;
        end
        case (state)
            IDLE: begin
                tx_n = ISP_UART_IDLE_LEVEL;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
`ifdef ISP_UART_PARITY_EN
                    parity_n = even_parity(9'(head));
`endif
                    baud_n  = BAUD_LOAD;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    bit_n   = '0;
                    tx_n    = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_DATA) begin
`ifdef ISP_UART_PARITY_EN
                        state_n = PARITY;
                        tx_n    = parity_q;
`else
                        state_n = STOP;
                        tx_n    = ISP_UART_IDLE_LEVEL;
                        bit_n   = '0;
`endif
                    end else begin
                        shift_n = shift >> 1;
                        tx_n    = shift_n[0];
                        bit_n   = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef ISP_UART_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                    tx_n    = ISP_UART_IDLE_LEVEL;
                    bit_n   = '0;
                end
            end
`endif
            STOP: begin
                tx_n = ISP_UART_IDLE_LEVEL;
                if (tick) begin
                    if (bit_cnt != LAST_STOP) begin
                        bit_n = bit_cnt + 1'b1;
                    end else if (IDLE_BITS > 0) begin
                        state_n = GAP;
                        bit_n   = '0;
                    end else begin
                        state_n = IDLE;
                        baud_n  = '0;
                        done_n  = 1'b1;
                    end
                end
            end
            GAP: begin
                tx_n = ISP_UART_IDLE_LEVEL;
                if (tick) begin
                    if (bit_cnt != LAST_GAP) begin
                        bit_n = bit_cnt + 1'b1;
                    end else begin
                        state_n = IDLE;
                        baud_n  = '0;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
                tx_n    = ISP_UART_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx_q    <= ISP_UART_IDLE_LEVEL;
            done_q  <= 1'b0;
`ifdef ISP_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            tx_q    <= tx_n;
            done_q  <= done_n;
`ifdef ISP_UART_PARITY_EN
            parity_q <= parity_n;
`endif
        end
    end

endmodule

// File: tb/tb_isp_uart_driver.sv
// Bench for isp_uart_driver: two configurations checked every cycle against a
// frame-level reference model (bit list per byte, each bit held for CLK_DIV cycles).
module tb_isp_uart_driver;

`ifdef ISP_UART_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    // Instance 0: CLK_DIV=4, 1 stop, no gap, depth 4. Instance 1: CLK_DIV=2, 2 stop, 3 gap, depth 8.
    int div_c   [2] = '{4, 2};
    int stop_c  [2] = '{1, 2};
    int idle_c  [2] = '{0, 3};
    int depth_c [2] = '{4, 8};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] vld;
    logic [7:0] dat   [2];
    logic       ready [2];
    logic       tx    [2];
    logic       busy  [2];
    logic       done  [2];
    logic [2:0] level_a;
    logic [3:0] level_b;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    isp_uart_driver #(
        .CLK_DIV (4), .DATA_BITS (8), .STOP_BITS (1), .IDLE_BITS (0), .FIFO_DEPTH (4)
    ) u_dut_a (
        .clk (clk), .rst (rst), .in_valid (vld[0]), .in_data (dat[0]), .in_ready (ready[0]),
        .uart_tx (tx[0]), .busy (busy[0]), .fifo_level (level_a), .tx_done (done[0])
    );

    isp_uart_driver #(
        .CLK_DIV (2), .DATA_BITS (8), .STOP_BITS (2), .IDLE_BITS (3), .FIFO_DEPTH (8)
    ) u_dut_b (
        .clk (clk), .rst (rst), .in_valid (vld[1]), .in_data (dat[1]), .in_ready (ready[1]),
        .uart_tx (tx[1]), .busy (busy[1]), .fifo_level (level_b), .tx_done (done[1])
    );

    // Reference model state
    int         m_act  [2];
    int         m_t    [2];
    int         m_nb   [2];
    int         m_head [2];
    int         m_cnt  [2];
    logic       m_bits [2][32];
    logic [7:0] m_buf  [2][16];
    logic       m_acc  [2];
    logic       e_tx   [2];
    logic       e_done [2];

    task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s[%0d] at %0t: got %0h expected %0h", tag, i, $time, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_t[i] = 0; m_nb[i] = 0; m_head[i] = 0; m_cnt[i] = 0;
            m_acc[i] = 1'b0; e_tx[i] = 1'b1; e_done[i] = 1'b0;
        end
    endfunction

    // One clock edge, using the inputs and queue contents as they were before the edge.
    function automatic void model_step(int i);
        logic [7:0] b;
        logic       take;
        int         n;
        take      = vld[i] && (m_cnt[i] < depth_c[i]);
        m_acc[i]  = take;
        e_done[i] = 1'b0;
        if (m_act[i] != 0) begin
            m_t[i]++;
            if (m_t[i] == m_nb[i] * div_c[i]) begin
                m_act[i]  = 0;
                e_done[i] = 1'b1;
                e_tx[i]   = 1'b1;
            end else begin
                e_tx[i] = m_bits[i][m_t[i] / div_c[i]];
            end
        end else if (m_cnt[i] > 0) begin
            b = m_buf[i][m_head[i]];
            m_head[i] = (m_head[i] + 1) % 16;
            m_cnt[i]--;
            m_bits[i][0] = 1'b0;
            for (int k = 0; k < 8; k++) m_bits[i][1 + k] = b[k];
            n = 9;
            if (PAR != 0) begin
                m_bits[i][n] = ^b;
                n++;
            end
            for (int k = 0; k < stop_c[i] + idle_c[i]; k++) begin
                m_bits[i][n] = 1'b1;
                n++;
            end
            m_nb[i]  = n;
            m_act[i] = 1;
            m_t[i]   = 0;
            e_tx[i]  = 1'b0;
        end else begin
            e_tx[i] = 1'b1;
        end
        if (take) begin
            m_buf[i][(m_head[i] + m_cnt[i]) % 16] = dat[i];
            m_cnt[i]++;
        end
    endfunction

    task automatic check_outputs(input int i);
        check("uart_tx", i, tx[i], e_tx[i]);
        check("tx_done", i, done[i], e_done[i]);
        check("in_ready", i, ready[i], m_cnt[i] < depth_c[i]);
        check("busy", i, busy[i], (m_act[i] != 0) || (m_cnt[i] > 0));
        check("fifo_level", i, (i == 0) ? 32'(level_a) : 32'(level_b), m_cnt[i]);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        check_outputs(0);
        check_outputs(1);
    endtask

    // Holds in_valid on one instance until the model says the byte was accepted.
    task automatic send(input int i, input logic [7:0] b);
        int n = 0;
        vld[i] = 1'b1;
        dat[i] = b;
        do begin
            cycle();
            n++;
        end while (!m_acc[i] && n < 400);
        check("accept_timeout", i, m_acc[i], 1);
        vld[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy[0] || busy[1]) && n < 3000) begin
            cycle();
            n++;
        end
        check("drain_busy", 0, busy[0], 0);
        check("drain_busy", 1, busy[1], 0);
        repeat (3) cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fall_n;
        int hi;

        vld    = '0;
        dat[0] = '0;
        dat[1] = '0;
        model_reset();
        #12;
        check_outputs(0);
        check_outputs(1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) cycle();

        // Single byte: line falls one edge after acceptance, tx_done CLK_DIV*(10+P)+1 edges after it.
        send(0, 8'hA5);
        n = 0;
        fall_n = -1;
        while (!done[0] && n < 200) begin
            cycle();
            n++;
            if (fall_n < 0 && tx[0] == 1'b0) fall_n = n;
        end
        check("fall_latency", 0, fall_n, 1);
        check("done_latency", 0, n, 4 * (10 + PAR) + 1);
        check("busy_at_done", 0, busy[0], 0);
        send(0, 8'h07);
        drain();

        // Back-pressure: six bytes with in_valid held throughout.
        for (int b = 1; b <= 6; b++) begin
            if (b == 6) begin
                check("full_level", 0, level_a, 4);
                check("full_ready", 0, ready[0], 0);
            end
            send(0, 8'(b));
        end
        drain();

        // Push on the same edge as the IDLE pop with one byte queued.
        send(0, 8'h3C);
        check("pre_pushpop_level", 0, level_a, 1);
        send(0, 8'hC3);
        check("pushpop_level", 0, level_a, 1);
        drain();

        // Stop and gap bits: high run between two all-zero frames is 2*2 + 3*2 + 1 cycles.
        send(1, 8'h00);
        send(1, 8'h00);
        n = 0;
        while (tx[1] == 1'b1 && n < 100) begin cycle(); n++; end
        while (tx[1] == 1'b0 && n < 100) begin cycle(); n++; end
        hi = 0;
        while (tx[1] == 1'b1 && n < 100) begin cycle(); n++; hi++; end
        check("gap_high_cycles", 1, hi, 2 * 2 + 3 * 2 + 1);
        drain();

        // Reset during data bit 3 of 0x55 with two more bytes queued.
        send(0, 8'h55);
        send(0, 8'h11);
        send(0, 8'h22);
        n = 0;
        while (!(m_act[0] != 0 && m_t[0] / div_c[0] == 4) && n < 200) begin cycle(); n++; end
        check("pre_reset_line", 0, tx[0], 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs(0);
        check_outputs(1);
        repeat (2) cycle();
        rst = 1'b0;
        repeat (60) cycle();
        check("post_reset_level", 0, level_a, 0);

        // Randomised traffic on both instances.
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < 2; i++) begin
                vld[i] = ($urandom_range(0, 3) == 0);
                dat[i] = 8'($urandom);
            end
            cycle();
        end
        vld = '0;
        drain();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
